text_buffer_ctrl: RTL and testbench



---
 rtl/text_pkg.sv | 46 ++++
 rtl/text_buffer_ctrl_if.sv | 16 +
 rtl/text_wfifo.sv | 49 ++++
 rtl/text_buffer_ctrl.sv | 151 +++++++++++++++
 tb/tb_text_buffer_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// Shared definitions for the character-cell buffer controller.
// Holds the text-area geometry, the cell word layout, the clear glyph,
// the write-FIFO entry layout and the clear-sequencer state encoding.
package text_pkg;

    localparam int unsigned CELL_W     = 14;
    localparam int unsigned COLS       = 80;
    localparam int unsigned ROWS       = 60;
    localparam int unsigned CX_W       = 7;
    localparam int unsigned CY_W       = 6;
    localparam int unsigned ADDR_W     = CY_W + CX_W;
    localparam int unsigned COLOUR_W   = 6;
    localparam int unsigned ASCII_W    = 7;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CNT_W = FIFO_PTR_W + 1;

    // Cell word field positions: {chl, colour[5:0], ascii[6:0]}
    localparam int unsigned CELL_HL_BIT  = 13;
    localparam int unsigned CELL_COL_MSB = 12;
    localparam int unsigned CELL_COL_LSB = 7;
    localparam int unsigned CELL_ASC_MSB = 6;
    localparam int unsigned CELL_ASC_LSB = 0;

    localparam logic [ASCII_W-1:0] CLR_GLYPH = 7'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_e;

    typedef struct packed {
        logic [CY_W-1:0]   cy;
        logic [CX_W-1:0]   cx;
        logic [CELL_W-1:0] data;
    } wr_entry_t;

    localparam int unsigned WR_ENTRY_W = $bits(wr_entry_t);

    // Cell word written by the clear sequencer
    function automatic logic [CELL_W-1:0] clr_cell(input logic [COLOUR_W-1:0] colour);
        return {1'b0, colour, CLR_GLYPH};
    endfunction

endpackage

// File: rtl/text_buffer_ctrl_if.sv
// Posted cell-write channel from the terminal/CPU writer.
//   wr_valid  writer request        wr_ready  writer may push this cycle
//   wr_cx     cell column           wr_cy     cell row
//   wr_data   cell word {chl, colour, ascii}
interface text_buffer_ctrl_if;
    import text_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [CX_W-1:0]   wr_cx;
    logic [CY_W-1:0]   wr_cy;
    logic [CELL_W-1:0] wr_data;

    modport master (output wr_valid, wr_cx, wr_cy, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_cx, wr_cy, wr_data, output wr_ready);
endinterface

// File: rtl/text_wfifo.sv
// Small synchronous write-request FIFO (FIFO_DEPTH entries of wr_entry_t).
//   push/wdata  enqueue        pop      dequeue head
//   rdata_c     head entry     full_c / empty_c  occupancy flags
//   count       registered occupancy
module text_wfifo
    import text_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WR_ENTRY_W-1:0] wdata,
    output logic [WR_ENTRY_W-1:0] rdata_c,
    output logic                  full_c,
    output logic                  empty_c,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [WR_ENTRY_W-1:0] store [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wptr_q;
    logic [FIFO_PTR_W-1:0] rptr_q;
    logic                  do_push_c;
    logic                  do_pop_c;

    assign full_c    = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty_c   = (count == '0);
    assign do_push_c = push && !full_c;
    assign do_pop_c  = pop && !empty_c;
    assign rdata_c   = store[rptr_q];

    // Pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) wptr_q <= wptr_q + FIFO_PTR_W'(1);
            if (do_pop_c)  rptr_q <= rptr_q + FIFO_PTR_W'(1);
            count <= count + FIFO_CNT_W'(do_push_c) - FIFO_CNT_W'(do_pop_c);
        end
    end

    // Storage needs no reset: occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push_c) store[wptr_q] <= wdata;
    end

endmodule

// File: rtl/text_buffer_ctrl.sv
// Arbiter for the single-port character-cell RAM.
// Even cycles (phase 0) carry the renderer's read; odd cycles (phase 1)
// retire one buffered write or one clear-screen write.
//   clk, resetn            clock, async active-low reset
//   rd_cx, rd_cy           renderer cell address
//   cascii/ccolour/chl     cell fields of the last render read
//   wr                     posted write channel (slave)
//   clr_req, clr_colour    clear-screen request and fill colour
//   busy                   clear pending or in progress
//   mem_addr/we/wdata      RAM port, mem_rdata 1-cycle read data
module text_buffer_ctrl
    import text_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic [CX_W-1:0]     rd_cx,
    input  logic [CY_W-1:0]     rd_cy,
    output logic [ASCII_W-1:0]  cascii,
    output logic [COLOUR_W-1:0] ccolour,
    output logic                chl,
    text_buffer_ctrl_if.slave   wr,
    input  logic                clr_req,
    input  logic [COLOUR_W-1:0] clr_colour,
    output logic                busy,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [CELL_W-1:0]   mem_wdata,
    input  logic [CELL_W-1:0]   mem_rdata
);

    state_e                state_q;
    state_e                state_nxt;
    logic                  phase_q;
    logic [CX_W-1:0]       clr_cx_q;
    logic [CY_W-1:0]       clr_cy_q;
    logic [COLOUR_W-1:0]   clr_colour_q;
    logic                  wr_ready_q;

    logic [WR_ENTRY_W-1:0] fifo_rdata_c;
    logic                  fifo_full_c;
    logic                  fifo_empty_c;
    logic [FIFO_CNT_W-1:0] fifo_cnt;
    logic [FIFO_CNT_W-1:0] cnt_nxt;
    wr_entry_t             head;
    wr_entry_t             in_entry;

    logic slot_nxt_c, in_range_c, accept_c, bypass_c, push_c, pop_c;
    logic clr_wr_c, clr_last_c;

    assign wr.wr_ready = wr_ready_q;
    assign head        = wr_entry_t'(fifo_rdata_c);
    assign in_entry    = wr_entry_t'({wr.wr_cy, wr.wr_cx, wr.wr_data});

    text_wfifo u_wfifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (push_c),
        .pop     (pop_c),
        .wdata   (in_entry),
        .rdata_c (fifo_rdata_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .count   (fifo_cnt)
    );

    // Slot decisions and clear-sequencer next state
    always_comb begin
        // Registers loaded at this edge drive the RAM during a write slot
        slot_nxt_c = !phase_q;
        in_range_c = (wr.wr_cx < CX_W'(COLS)) && (wr.wr_cy < CY_W'(ROWS));
        accept_c   = wr.wr_valid && wr_ready_q;
        pop_c      = slot_nxt_c && !fifo_empty_c && (state_q != CLEAR);
        // An empty FIFO lets a fresh write go straight into the coming write slot
        bypass_c   = slot_nxt_c && fifo_empty_c && accept_c && in_range_c;
        push_c     = accept_c && in_range_c && !bypass_c && !fifo_full_c;
        clr_wr_c   = slot_nxt_c && (state_q == CLEAR);
        clr_last_c = clr_wr_c && (clr_cx_q == CX_W'(COLS - 1)) && (clr_cy_q == CY_W'(ROWS - 1));
        cnt_nxt    = fifo_cnt + FIFO_CNT_W'(push_c) - FIFO_CNT_W'(pop_c);

        state_nxt = state_q;
        case (state_q)
            IDLE:    if (clr_req)      state_nxt = DRAIN;
            DRAIN:   if (fifo_empty_c) state_nxt = CLEAR;
            CLEAR:   if (clr_last_c)   state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Phase, FSM, clear cursor, RAM port and render outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_q      <= 1'b0;
            state_q      <= IDLE;
            clr_cx_q     <= '0;
            clr_cy_q     <= '0;
            clr_colour_q <= '0;
            wr_ready_q   <= 1'b1;
            busy         <= 1'b0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            cascii       <= '0;
            ccolour      <= '0;
            chl          <= 1'b0;
        end else begin
            phase_q    <= ~phase_q;
            state_q    <= state_nxt;
            busy       <= (state_nxt != IDLE);
            wr_ready_q <= (cnt_nxt != FIFO_CNT_W'(FIFO_DEPTH)) && (state_nxt == IDLE);

            if ((state_q == IDLE) && clr_req) clr_colour_q <= clr_colour;

            if (state_q == DRAIN) begin
                clr_cx_q <= '0;
                clr_cy_q <= '0;
            end else if (clr_wr_c) begin
                if (clr_cx_q == CX_W'(COLS - 1)) begin
                    clr_cx_q <= '0;
                    clr_cy_q <= clr_cy_q + CY_W'(1);
                end else begin
                    clr_cx_q <= clr_cx_q + CX_W'(1);
                end
            end

            if (phase_q) begin
                // Entering the render slot; read data of the previous render slot is valid now
                mem_we   <= 1'b0;
                mem_addr <= {rd_cy, rd_cx};
                chl      <= mem_rdata[CELL_HL_BIT];
                ccolour  <= mem_rdata[CELL_COL_MSB:CELL_COL_LSB];
                cascii   <= mem_rdata[CELL_ASC_MSB:CELL_ASC_LSB];
            end else if (pop_c) begin
                mem_we    <= 1'b1;
                mem_addr  <= {head.cy, head.cx};
                mem_wdata <= head.data;
            end else if (bypass_c) begin
                mem_we    <= 1'b1;
                mem_addr  <= {in_entry.cy, in_entry.cx};
                mem_wdata <= in_entry.data;
            end else if (clr_wr_c) begin
                mem_we    <= 1'b1;
                mem_addr  <= {clr_cy_q, clr_cx_q};
                mem_wdata <= clr_cell(clr_colour_q);
            end else begin
                // Idle write slot: address holds
                mem_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Self-checking bench for text_buffer_ctrl.
// A behavioural RAM sits on the memory port; a reference model keeps the
// ordered list of RAM writes the writer and clear requests imply, plus a
// shadow copy of cell contents used to predict render outputs.
module tb_text_buffer_ctrl;
    import text_pkg::*;

    logic                clk;
    logic                resetn;
    logic [CX_W-1:0]     rd_cx;
    logic [CY_W-1:0]     rd_cy;
    logic [ASCII_W-1:0]  cascii;
    logic [COLOUR_W-1:0] ccolour;
    logic                chl;
    logic                clr_req;
    logic [COLOUR_W-1:0] clr_colour;
    logic                busy;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_we;
    logic [CELL_W-1:0]   mem_wdata;
    logic [CELL_W-1:0]   mem_rdata;

    text_buffer_ctrl_if wif();

    text_buffer_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .rd_cx      (rd_cx),
        .rd_cy      (rd_cy),
        .cascii     (cascii),
        .ccolour    (ccolour),
        .chl        (chl),
        .wr         (wif),
        .clr_req    (clr_req),
        .clr_colour (clr_colour),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, read-before-write, 1-cycle read latency
    logic [CELL_W-1:0] ram [0:8191];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [CELL_W-1:0] d;
    } exp_t;

    exp_t              exp_q[$];
    logic [CELL_W-1:0] shadow [0:8191];
    bit                known  [0:8191];
    int                n_chk = 0;
    int                n_pass = 0;
    int                n_wr = 0;
    int                last_wr_cyc = 0;
    int                cyc;
    int                wr_cyc_q[$];
    bit                saw_stall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Cycle index since reset release; even index = render slot
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Every RAM write must be in a write slot and match the model's next write
    always @(negedge clk) begin
        if (resetn && mem_we) begin
            exp_t e;
            check("we_in_write_slot", 32'(cyc % 2), 32'd1);
            n_wr++;
            last_wr_cyc = cyc;
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.a));
                check("wr_data", 32'(mem_wdata), 32'(e.d));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic void model_accept(input logic [6:0] cx, input logic [5:0] cy, input logic [13:0] d);
        logic [12:0] a;
        if (cx < 7'(COLS) && cy < 6'(ROWS)) begin
            a = {cy, cx};
            exp_q.push_back('{a: a, d: d});
            shadow[a] = d;
            known[a]  = 1'b1;
        end
    endfunction

    function automatic void model_clear(input logic [5:0] colour);
        logic [13:0] c;
        logic [12:0] a;
        c = {1'b0, colour, 7'h20};
        for (int y = 0; y < int'(ROWS); y++) begin
            for (int x = 0; x < int'(COLS); x++) begin
                a = {6'(y), 7'(x)};
                exp_q.push_back('{a: a, d: c});
                shadow[a] = c;
                known[a]  = 1'b1;
            end
        end
    endfunction

    task automatic push_write(input logic [6:0] cx, input logic [5:0] cy, input logic [13:0] d,
                              output int acc_cyc);
        bit done;
        done    = 1'b0;
        acc_cyc = -1;
        wif.wr_valid = 1'b1;
        wif.wr_cx    = cx;
        wif.wr_cy    = cy;
        wif.wr_data  = d;
        for (int i = 0; i < 64 && !done; i++) begin
            if (wif.wr_ready) begin
                done    = 1'b1;
                acc_cyc = cyc;
                model_accept(cx, cy, d);
            end else begin
                saw_stall = 1'b1;
            end
            step();
        end
        wif.wr_valid = 1'b0;
        if (!done) check("push_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && (exp_q.size() != 0 || busy); i++) step();
        repeat (3) step();
        check("drain_done", 32'(exp_q.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_wr_ready", 32'(wif.wr_ready), 32'd1);
    endtask

    task automatic render_check(input logic [6:0] cx, input logic [5:0] cy);
        logic [12:0] a;
        rd_cx = cx;
        rd_cy = cy;
        repeat (5) step();
        a = {cy, cx};
        if (known[a]) begin
            check("cascii", 32'(cascii), 32'(shadow[a][6:0]));
            check("ccolour", 32'(ccolour), 32'(shadow[a][12:7]));
            check("chl", 32'(chl), 32'(shadow[a][13]));
        end
    endtask

    task automatic check_reset_values();
        check("rst_cascii", 32'(cascii), 32'd0);
        check("rst_ccolour", 32'(ccolour), 32'd0);
        check("rst_chl", 32'(chl), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_wr_ready", 32'(wif.wr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int          acc;
        int          n0;
        int          lat;
        logic [6:0]  cx;
        logic [5:0]  cy;
        logic [12:0] addr_list[$];
        bit          found;

        resetn       = 1'b0;
        rd_cx        = '0;
        rd_cy        = '0;
        clr_req      = 1'b0;
        clr_colour   = '0;
        wif.wr_valid = 1'b0;
        wif.wr_cx    = '0;
        wif.wr_cy    = '0;
        wif.wr_data  = '0;
        repeat (3) step();
        check_reset_values();
        resetn = 1'b1;
        step();

        // Directed cell, then isolated writes in both slot phases for latency
        push_write(7'd5, 6'd2, 14'h2A41, acc);
        wait_idle(50);
        render_check(7'd5, 6'd2);
        check("dir_cascii", 32'(cascii), 32'h41);
        check("dir_ccolour", 32'(ccolour), 32'h14);
        check("dir_chl", 32'(chl), 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 1) step();
            n0 = n_wr;
            push_write(7'($urandom_range(0, 79)), 6'($urandom_range(0, 59)), 14'($urandom), acc);
            for (int k = 0; k < 10 && n_wr == n0; k++) step();
            lat = last_wr_cyc - acc;
            check("wr_latency_1_to_2", 32'(n_wr > n0 && lat >= 1 && lat <= 2), 32'd1);
            wait_idle(20);
        end

        // Out-of-range writes are acknowledged but never reach the RAM
        n0 = n_wr;
        push_write(7'd80, 6'd0, 14'h1234, acc);
        check("oor_col_ack", 32'(acc >= 0), 32'd1);
        push_write(7'd0, 6'd60, 14'h0567, acc);
        check("oor_row_ack", 32'(acc >= 0), 32'd1);
        repeat (10) step();
        check("oor_no_write", 32'(n_wr - n0), 32'd0);
        check("oor_wr_ready", 32'(wif.wr_ready), 32'd1);

        // Back-to-back burst: fills the FIFO, retires one write per 2 clk in order
        wr_cyc_q.delete();
        saw_stall = 1'b0;
        for (int i = 0; i < 10; i++)
            push_write(7'(i * 3), 6'(i + 10), 14'(14'h0100 + i), acc);
        wait_idle(100);
        check("burst_stall_seen", 32'(saw_stall), 32'd1);
        check("burst_count", 32'(wr_cyc_q.size()), 32'd10);
        for (int i = 1; i < wr_cyc_q.size(); i++)
            check("burst_spacing", 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'd2);

        // Randomized traffic with gaps and occasional out-of-range cells
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            cx = ($urandom_range(0, 9) == 0) ? 7'(80 + $urandom_range(0, 47)) : 7'($urandom_range(0, 79));
            cy = ($urandom_range(0, 9) == 0) ? 6'(60 + $urandom_range(0, 3)) : 6'($urandom_range(0, 59));
            push_write(cx, cy, 14'($urandom), acc);
            if (cx < 7'(COLS) && cy < 6'(ROWS)) addr_list.push_back({cy, cx});
        end
        wait_idle(400);
        for (int i = 0; i < 12; i++) begin
            logic [12:0] a;
            a = addr_list[$urandom_range(0, addr_list.size() - 1)];
            render_check(a[6:0], a[12:7]);
        end

        // Clear with 3 writes queued ahead; a second request mid-clear is ignored
        n0 = n_wr;
        push_write(7'd1, 6'd1, 14'h3FFF, acc);
        push_write(7'd2, 6'd1, 14'h0ABC, acc);
        push_write(7'd3, 6'd1, 14'h1DEF, acc);
        clr_req    = 1'b1;
        clr_colour = 6'h03;
        model_clear(6'h03);
        step();
        clr_req = 1'b0;
        check("clr_busy", 32'(busy), 32'd1);
        check("clr_wr_ready", 32'(wif.wr_ready), 32'd0);
        repeat (200) step();
        clr_req    = 1'b1;
        clr_colour = 6'h15;
        step();
        clr_req = 1'b0;
        check("clr_busy_mid", 32'(busy), 32'd1);
        wait_idle(12000);
        check("clr_write_count", 32'(n_wr - n0), 32'd4803);
        render_check(7'd0, 6'd0);
        render_check(7'd79, 6'd59);
        render_check(7'd2, 6'd1);
        check("clr_cell_value", 32'({chl, ccolour, cascii}), 32'h01A0);

        // Reset in the middle of a clear aborts it immediately
        clr_req    = 1'b1;
        clr_colour = 6'(($urandom_range(0, 62)));
        model_clear(clr_colour);
        step();
        clr_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            step();
            if (mem_we && mem_addr == 13'({6'd20, 7'd10})) found = 1'b1;
        end
        check("clr_reached_10_20", 32'(found), 32'd1);
        resetn = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        for (int i = 0; i < 8192; i++) known[i] = 1'b0;
        repeat (2) step();
        resetn = 1'b1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_wr_ready", 32'(wif.wr_ready), 32'd1);
        n0 = n_wr;
        repeat (10) step();
        check("post_rst_no_writes", 32'(n_wr - n0), 32'd0);
        push_write(7'd33, 6'd44, 14'h2C7E, acc);
        wait_idle(50);
        render_check(7'd33, 6'd44);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
